// File: rtl/cr16_issue_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cr16_issue_fsm                                               |
// | Description : CR16 instruction issue FSM. Accepts one instruction over a   |
// |               valid/ready handshake, decodes it and sequences the          |
// |               datapath through an operand-read cycle and a writeback       |
// |               cycle.                                                       |
// |               Optional macro CR16_ISSUE_RETIRE_COUNT_EN adds a saturating  |
// |               16-bit retired-instruction counter (O_RETIRE_COUNT).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cr16_issue_fsm #(
  parameter int REG_COUNT = 16,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET,
  input  logic [15:0]          I_INSTR,
  input  logic                 I_INSTR_VALID,
  output logic                 O_INSTR_READY,
  output logic                 O_DP_NRESET,
  output logic [REG_COUNT-1:0] O_REG_WRITE_ENABLE,
  output logic [SEL_WIDTH-1:0] O_REG_A_SELECT,
  output logic [SEL_WIDTH-1:0] O_REG_B_SELECT,
  output logic [15:0]          O_IMMEDIATE,
  output logic                 O_IMMEDIATE_SELECT,
  output logic [3:0]           O_OPCODE,
  output logic                 O_DONE,
`ifdef CR16_ISSUE_RETIRE_COUNT_EN
  output logic [15:0]          O_RETIRE_COUNT,
`endif
  output logic                 O_ILLEGAL
);

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_READ  = 2'd1;
  localparam logic [1:0] C_ST_WRITE = 2'd2;

  // ALU opcodes
  localparam logic [3:0] C_ALU_ADD = 4'd0;
  localparam logic [3:0] C_ALU_SUB = 4'd1;
  localparam logic [3:0] C_ALU_CMP = 4'd2;
  localparam logic [3:0] C_ALU_AND = 4'd3;
  localparam logic [3:0] C_ALU_OR  = 4'd4;
  localparam logic [3:0] C_ALU_XOR = 4'd5;
  localparam logic [3:0] C_ALU_MOV = 4'd6;

  // Shared encoding of the R-type ext field and the I-type op field
  localparam logic [3:0] C_ENC_ADD = 4'b0101;
  localparam logic [3:0] C_ENC_SUB = 4'b1001;
  localparam logic [3:0] C_ENC_CMP = 4'b1011;
  localparam logic [3:0] C_ENC_AND = 4'b0001;
  localparam logic [3:0] C_ENC_OR  = 4'b0010;
  localparam logic [3:0] C_ENC_XOR = 4'b0011;
  localparam logic [3:0] C_ENC_MOV = 4'b1101;
  localparam logic [3:0] C_OP_RTYPE = 4'b0000;
  localparam logic [3:0] C_OP_LUI   = 4'b1111;

  localparam logic [REG_COUNT-1:0] C_ONE_HOT_BASE = {{(REG_COUNT-1){1'b0}}, 1'b1};

  logic [1:0]  r_state;
  logic [15:0] r_instr;
  logic        r_dp_nreset;

  logic [3:0]  w_op;
  logic [3:0]  w_ext;
  logic [7:0]  w_imm8;
  logic [3:0]  w_rdest;
  logic [3:0]  w_rsrc;

  logic        w_legal;
  logic        w_writes;
  logic        w_imm_sel;
  logic [3:0]  w_alu_op;
  logic [15:0] w_imm;
  logic        w_in_write;

  assign w_op    = r_instr[15:12];
  assign w_rdest = r_instr[11:8];
  assign w_ext   = r_instr[7:4];
  assign w_rsrc  = r_instr[3:0];
  assign w_imm8  = r_instr[7:0];

  // State sequencing and instruction capture; reset discards any instruction in flight
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state <= C_ST_IDLE;
      r_instr <= 16'h0000;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (I_INSTR_VALID) begin
            r_state <= C_ST_READ;
            r_instr <= I_INSTR;
          end
        end
        C_ST_READ:  r_state <= C_ST_WRITE;
        C_ST_WRITE: r_state <= C_ST_IDLE;
        default:    r_state <= C_ST_IDLE;
      endcase
    end
  end

  // Datapath reset follows our own reset, registered so it is glitch-free
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_dp_nreset <= 1'b0;
    end else begin
      r_dp_nreset <= 1'b1;
    end
  end

  // Decode of the latched instruction; illegal encodings drive neutral controls
  always_comb begin
    w_legal   = 1'b0;
    w_writes  = 1'b0;
    w_imm_sel = 1'b0;
    w_alu_op  = C_ALU_ADD;
    w_imm     = 16'h0000;
    if (w_op == C_OP_RTYPE) begin
      w_legal  = 1'b1;
      w_writes = 1'b1;
      case (w_ext)
        C_ENC_ADD: w_alu_op = C_ALU_ADD;
        C_ENC_SUB: w_alu_op = C_ALU_SUB;
        C_ENC_CMP: begin
          w_alu_op = C_ALU_CMP;
          w_writes = 1'b0;
        end
        C_ENC_AND: w_alu_op = C_ALU_AND;
        C_ENC_OR:  w_alu_op = C_ALU_OR;
        C_ENC_XOR: w_alu_op = C_ALU_XOR;
        C_ENC_MOV: w_alu_op = C_ALU_MOV;
        default: begin
          w_legal  = 1'b0;
          w_writes = 1'b0;
        end
      endcase
    end else begin
      w_legal   = 1'b1;
      w_writes  = 1'b1;
      w_imm_sel = 1'b1;
      case (w_op)
        C_ENC_ADD: begin
          w_alu_op = C_ALU_ADD;
          w_imm    = {{8{w_imm8[7]}}, w_imm8};
        end
        C_ENC_SUB: begin
          w_alu_op = C_ALU_SUB;
          w_imm    = {{8{w_imm8[7]}}, w_imm8};
        end
        C_ENC_CMP: begin
          w_alu_op = C_ALU_CMP;
          w_imm    = {{8{w_imm8[7]}}, w_imm8};
          w_writes = 1'b0;
        end
        C_ENC_AND: begin
          w_alu_op = C_ALU_AND;
          w_imm    = {8'h00, w_imm8};
        end
        C_ENC_OR: begin
          w_alu_op = C_ALU_OR;
          w_imm    = {8'h00, w_imm8};
        end
        C_ENC_XOR: begin
          w_alu_op = C_ALU_XOR;
          w_imm    = {8'h00, w_imm8};
        end
        C_ENC_MOV: begin
          w_alu_op = C_ALU_MOV;
          w_imm    = {8'h00, w_imm8};
        end
        C_OP_LUI: begin
          w_alu_op = C_ALU_MOV;
          w_imm    = {w_imm8, 8'h00};
        end
        default: begin
          w_legal   = 1'b0;
          w_writes  = 1'b0;
          w_imm_sel = 1'b0;
        end
      endcase
    end
  end

  assign w_in_write = (r_state == C_ST_WRITE);

  // Controls come only from state and the latched instruction, so they hold in IDLE
  assign O_INSTR_READY      = (r_state == C_ST_IDLE);
  assign O_DP_NRESET        = r_dp_nreset;
  assign O_REG_A_SELECT     = SEL_WIDTH'(w_rdest);
  assign O_REG_B_SELECT     = SEL_WIDTH'(w_rsrc);
  assign O_IMMEDIATE        = w_imm;
  assign O_IMMEDIATE_SELECT = w_imm_sel;
  assign O_OPCODE           = w_alu_op;
  assign O_DONE             = w_in_write;
  assign O_ILLEGAL          = w_in_write & ~w_legal;
  assign O_REG_WRITE_ENABLE = (w_in_write && w_writes) ? (C_ONE_HOT_BASE << w_rdest)
                                                       : {REG_COUNT{1'b0}};

`ifdef CR16_ISSUE_RETIRE_COUNT_EN
  logic [15:0] r_retire_count;

  // Saturating count of retired instructions, illegal ones included
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_retire_count <= 16'h0000;
    end else if (w_in_write && (r_retire_count != 16'hFFFF)) begin
      r_retire_count <= r_retire_count + 16'h0001;
    end
  end

  assign O_RETIRE_COUNT = r_retire_count;
`endif

endmodule
`default_nettype wire

// File: doc/cr16_issue_fsm.md
Name: cr16_issue_fsm

Overview:
- Upstream control stage for the CR16 datapath. Replaces the hard-wired test-sequence FSM as the source of the datapath control signals.
- Accepts one 16-bit CR16 instruction at a time over a valid/ready handshake and decodes it.
- Sequences the datapath through an operand-read cycle and a writeback cycle by driving the one-hot register write enable, the A/B read selects, the immediate, the immediate select and the ALU opcode.

Parameters:
- REG_COUNT, 16, number of architectural registers; sets the width of O_REG_WRITE_ENABLE.
- SEL_WIDTH, 4, width of register select fields; equals log2(REG_COUNT).

Ports:
- I_CLK  input  1  system clock; all state updates on its rising edge.
- I_RESET  input  1  synchronous, active-high reset.
- I_INSTR  input  16  CR16 instruction word.
- I_INSTR_VALID  input  1  I_INSTR is valid this cycle.
- O_INSTR_READY  output  1  block can accept an instruction this cycle.
- O_DP_NRESET  output  1  drives datapath I_NRESET; 0 while I_RESET is high, else 1.
- O_REG_WRITE_ENABLE  output  REG_COUNT  one-hot register write enable.
- O_REG_A_SELECT  output  SEL_WIDTH  binary read select A (Rdest).
- O_REG_B_SELECT  output  SEL_WIDTH  binary read select B (Rsrc).
- O_IMMEDIATE  output  16  extended immediate.
- O_IMMEDIATE_SELECT  output  1  selects the immediate as the B operand.
- O_OPCODE  output  4  ALU opcode.
- O_DONE  output  1  one-cycle pulse when an instruction retires.
- O_ILLEGAL  output  1  one-cycle pulse, coincident with O_DONE, for an undecodable instruction.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; the ports are I_CLK and I_RESET.
- All outputs are registered or decoded only from the state and the latched instruction; no combinational path from I_INSTR to outputs.
- Reset values: state IDLE, latched instruction 0, all outputs 0 except O_INSTR_READY=1. O_DP_NRESET=0 during any cycle in which I_RESET is sampled high.
- States and transitions:
  - IDLE -> READ on I_INSTR_VALID & O_INSTR_READY; I_INSTR is latched on that edge.
  - READ -> WRITE unconditionally.
  - WRITE -> IDLE unconditionally.
- O_INSTR_READY=1 only in IDLE. Throughput is one instruction per 3 cycles.
- READ: selects, immediate, immediate select and opcode are driven from the latched instruction; O_REG_WRITE_ENABLE=0.
- WRITE: the same values are held. O_REG_WRITE_ENABLE = 1<<Rdest for writing instructions, else 0. O_DONE=1.
- IDLE: O_REG_WRITE_ENABLE=0. The other control outputs hold their last values.
- Instruction fields: Rdest=[11:8], Rsrc=[3:0], op=[15:12], ext=[7:4], imm8=[7:0].
- R-type (op=0000), ext -> ALU opcode: ADD 0101 -> 0, SUB 1001 -> 1, CMP 1011 -> 2, AND 0001 -> 3, OR 0010 -> 4, XOR 0011 -> 5, MOV 1101 -> 6.
- I-type, same op nibble as the ext values above: ADDI, SUBI, CMPI, ANDI, ORI, XORI, MOVI use ALU opcodes 0..6 with O_IMMEDIATE_SELECT=1. LUI (op=1111) uses ALU opcode 6 with O_IMMEDIATE_SELECT=1.
- Immediate extension:
  - ADDI, SUBI, CMPI: sign-extend imm8.
  - ANDI, ORI, XORI, MOVI: zero-extend imm8.
  - LUI: {imm8, 8'h00}.
  - R-type: O_IMMEDIATE=0.
- CMP and CMPI never write: enable stays 0 in WRITE, and flags update inside the datapath.
- Any other encoding is illegal: it traverses READ and WRITE with enable 0, and O_ILLEGAL=1 together with O_DONE in WRITE.
- I_INSTR_VALID outside IDLE is ignored. The source must hold the instruction until ready.
- Reset mid-operation: the latched instruction is discarded, no write enable is asserted, and the block returns to IDLE on the next edge.
- Rdest=Rsrc is legal; no special handling.

Optional Feature:
- Macro CR16_ISSUE_RETIRE_COUNT_EN.
- Defined: adds output O_RETIRE_COUNT [15:0].
  - Increments by 1 on every O_DONE cycle, including illegal instructions.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by I_RESET.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: I_RESET=1 for 2 cycles -> O_INSTR_READY=1, O_REG_WRITE_ENABLE=0, O_DP_NRESET=0; the cycle after release, O_DP_NRESET=1.
- ADDI r1,#-3 (16'h51FD) -> READ: A=1, O_IMMEDIATE=16'hFFFD, O_IMMEDIATE_SELECT=1, O_OPCODE=0, enable=0; WRITE: enable=16'h0002, O_DONE=1; IDLE next cycle.
- ADD r2,r3 (16'h0253) -> A=2, B=3, O_IMMEDIATE_SELECT=0, O_OPCODE=0, enable=16'h0004 only in WRITE. Back-to-back valid -> next instruction accepted 3 cycles after the first.
- CMPI r4,#5 (16'hB405) -> O_OPCODE=2, O_IMMEDIATE=16'h0005, enable stays 0 for all cycles, O_DONE pulses once.
- LUI r7,#AB (16'hF7AB) -> O_IMMEDIATE=16'hAB00, enable=16'h0080. Illegal 16'h0E00 -> O_ILLEGAL and O_DONE for one cycle, enable stays 0.
- I_RESET asserted in READ of ADD r5,r6 -> no enable bit ever rises, IDLE after one edge. With CR16_ISSUE_RETIRE_COUNT_EN, O_RETIRE_COUNT is 0 after reset and 3 after three retirements.
